// File: rtl/nec_ir_transmitter.sv
// NEC IR frame transmitter: leader, 32 LSB-first data bits (addr, ~addr, cmd, ~cmd), stop mark.
// Drives a carrier-modulated LED output and the raw envelope for receiver loopback.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int MODULATE     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       ir_tx,
  output logic       ir_envelope,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER_MARK,
    S_LEADER_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } state_t;

  localparam int UNIT_W = $clog2(UNIT_CYCLES);
  localparam int CAR_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_HALF - 1);

  state_t              state_q, state_d;
  logic [UNIT_W-1:0]   unit_cnt_q, unit_cnt_d;
  logic [3:0]          units_left_q, units_left_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic [31:0]         shift_q, shift_d;
  logic [CAR_W-1:0]    car_cnt_q, car_cnt_d;
  logic                carrier_q, carrier_d;
  logic                env_q, env_d;
  logic                ir_tx_q, ir_tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic unit_tick;
  logic advance;
  logic mark_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      unit_cnt_q   <= '0;
      units_left_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      car_cnt_q    <= '0;
      carrier_q    <= 1'b0;
      env_q        <= 1'b0;
      ir_tx_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_cnt_q   <= unit_cnt_d;
      units_left_q <= units_left_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      car_cnt_q    <= car_cnt_d;
      carrier_q    <= carrier_d;
      env_q        <= env_d;
      ir_tx_q      <= ir_tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // units_left holds (remaining units - 1) of the current state; a state ends
  // on the unit tick that finds it at zero.
  always_comb begin
    state_d      = state_q;
    unit_cnt_d   = unit_cnt_q;
    units_left_d = units_left_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    unit_tick    = (unit_cnt_q == UNIT_LAST);
    advance      = unit_tick && (units_left_q == 4'd0);

    if (state_q != S_IDLE) begin
      if (unit_tick) begin
        unit_cnt_d = '0;
        if (units_left_q != 4'd0) begin
          units_left_d = units_left_q - 4'd1;
        end
      end else begin
        unit_cnt_d = unit_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d      = S_LEADER_MARK;
          shift_d      = {~command, command, ~address, address};
          unit_cnt_d   = '0;
          units_left_d = 4'd15;
          bit_idx_d    = '0;
        end
      end
      S_LEADER_MARK: begin
        if (advance) begin
          state_d      = S_LEADER_SPACE;
          units_left_d = 4'd7;
        end
      end
      S_LEADER_SPACE: begin
        if (advance) begin
          state_d      = S_BIT_MARK;
          units_left_d = 4'd0;
        end
      end
      S_BIT_MARK: begin
        if (advance) begin
          state_d      = S_BIT_SPACE;
          units_left_d = shift_q[0] ? 4'd2 : 4'd0;
        end
      end
      S_BIT_SPACE: begin
        if (advance) begin
          shift_d      = {1'b0, shift_q[31:1]};
          bit_idx_d    = bit_idx_q + 5'd1;
          units_left_d = 4'd0;
          state_d      = (bit_idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK: begin
        if (advance) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from next-state values so the registers line up
  // exactly with the state they describe.
  always_comb begin
    mark_d    = (state_d == S_LEADER_MARK) || (state_d == S_BIT_MARK) ||
                (state_d == S_STOP_MARK);
    car_cnt_d = '0;
    carrier_d = 1'b0;
    if (mark_d && !env_q) begin
      carrier_d = 1'b1;
    end else if (mark_d) begin
      if (car_cnt_q == CAR_LAST) begin
        carrier_d = ~carrier_q;
      end else begin
        car_cnt_d = car_cnt_q + 1'b1;
        carrier_d = carrier_q;
      end
    end
    env_d   = mark_d;
    ir_tx_d = (MODULATE != 0) ? (mark_d & carrier_d) : mark_d;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP_MARK) && (unit_cnt_d == UNIT_LAST) &&
              (units_left_d == 4'd0);
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign ir_tx       = ir_tx_q;
  assign ir_envelope = env_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Scoreboarded bench: handshakes push the requested bytes, a frame monitor rebuilds
// each frame and compares it with a unit-level NEC waveform model.
module tb_nec_ir_transmitter;

  localparam int U         = 4;
  localparam int CH        = 1;
  localparam int FRAME_LEN = 121 * U;
  localparam int MARK_LEN  = 49 * U;

  typedef bit wave_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] command = 8'h00;
  logic       tx_ready, ir_tx, ir_envelope, busy, done;
  logic       tx_ready_nm, ir_tx_nm, env_nm, busy_nm, done_nm;

  nec_ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(1)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .address(address), .command(command), .ir_tx(ir_tx),
    .ir_envelope(ir_envelope), .busy(busy), .done(done)
  );

  nec_ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .MODULATE(0)) u_dut_nm (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready_nm),
    .address(address), .command(command), .ir_tx(ir_tx_nm),
    .ir_envelope(env_nm), .busy(busy_nm), .done(done_nm)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          hs_count = 0;
  int          frames_done = 0;
  logic [31:0] last_data = '0;
  int          nm_viol = 0;
  int          idle_viol = 0;
  int          rdy_viol = 0;
  bit          coll = 0;
  bit          obs_env[$];
  bit          obs_tx[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame built directly from NEC unit counts.
  function automatic wave_t build_wave(input logic [7:0] a, input logic [7:0] c);
    wave_t w;
    logic [31:0] d;
    d = {~c, c, ~a, a};
    repeat (16 * U) w.push_back(1'b1);
    repeat (8 * U) w.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin
      repeat (U) w.push_back(1'b1);
      repeat ((d[i] ? 3 : 1) * U) w.push_back(1'b0);
    end
    repeat (U) w.push_back(1'b1);
    return w;
  endfunction

  task automatic finish_frame();
    logic [15:0] e;
    logic [31:0] data;
    wave_t       w;
    int          ones, mism, carr_viol, k, n;
    bit          exp_t;
    int          runs_l[$];
    frames_done++;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 64'(obs_env.size()), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    w = build_wave(e[15:8], e[7:0]);
    check("frame_len", 64'(obs_env.size()), 64'(FRAME_LEN));
    ones = 0;
    mism = 0;
    carr_viol = 0;
    k = 0;
    n = (obs_env.size() > w.size()) ? obs_env.size() : w.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs_env.size() || i >= w.size()) mism++;
      else if (obs_env[i] != w[i]) mism++;
    end
    for (int i = 0; i < obs_env.size(); i++) begin
      if (obs_env[i]) begin
        ones++;
        exp_t = ((k / CH) % 2) == 0;
        k++;
      end else begin
        exp_t = 1'b0;
        k = 0;
      end
      if (obs_tx[i] != exp_t) carr_viol++;
    end
    check("mark_total", 64'(ones), 64'(MARK_LEN));
    check("envelope_wave", 64'(mism), 64'd0);
    check("carrier", 64'(carr_viol), 64'd0);
    check("ready_low_while_busy", 64'(rdy_viol), 64'd0);
    k = 1;
    for (int i = 1; i < obs_env.size(); i++) begin
      if (obs_env[i] == obs_env[i-1]) k++;
      else begin
        runs_l.push_back(k);
        k = 1;
      end
    end
    runs_l.push_back(k);
    data = '0;
    for (int b = 0; b < 32; b++) begin
      if (3 + 2 * b < runs_l.size()) data[b] = runs_l[3 + 2 * b] > 2 * U;
    end
    last_data = data;
    check("decoded_bytes", 64'(data), 64'({~e[7:0], e[7:0], ~e[15:8], e[15:8]}));
    $display("frame %0d: addr=0x%02h cmd=0x%02h len=%0d data=0x%08h",
             frames_done, e[15:8], e[7:0], obs_env.size(), data);
  endtask

  // Scoreboard producer: every accepted handshake records what must be sent.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      exp_q.push_back({address, command});
      hs_count++;
    end
  end

  // Frame monitor.
  always @(negedge clk) begin
    if (rst) begin
      coll = 0;
      obs_env.delete();
      obs_tx.delete();
      exp_q.delete();
    end else begin
      if (busy) begin
        if (!coll) begin
          coll = 1;
          rdy_viol = 0;
          obs_env.delete();
          obs_tx.delete();
        end
        obs_env.push_back(ir_envelope);
        obs_tx.push_back(ir_tx);
        if (tx_ready) rdy_viol++;
      end else if (ir_envelope || ir_tx || done) begin
        idle_viol++;
      end
      if (done) begin
        if (coll) finish_frame();
        else check("done_outside_frame", 64'd1, 64'd0);
        coll = 0;
      end
    end
    if (ir_tx_nm !== env_nm || env_nm !== ir_envelope || busy_nm !== busy ||
        done_nm !== done || tx_ready_nm !== tx_ready) nm_viol++;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] c);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    address = a;
    command = c;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("handshake_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) check("frame_timeout", 64'(frames_done), 64'(target));
  endtask

  initial begin
    int          hs0, f0, tcyc, idle, n;
    logic [7:0]  a, c;
    logic [31:0] d;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 64'({tx_ready, busy, ir_tx, ir_envelope, done}), 64'(5'b10000));
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 64'({tx_ready, busy, ir_tx, ir_envelope, done}), 64'(5'b10000));
    end

    // All-zero frame, then the known example frame.
    send(8'h00, 8'h00);
    wait_frames(1);
    check("zero_frame_data", 64'(last_data), 64'(32'hFF00_FF00));
    send(8'h59, 8'h16);
    wait_frames(2);
    check("example_frame_data", 64'(last_data), 64'(32'hE916_A659));

    // Random single frames.
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom), 8'($urandom));
      wait_frames(3 + i);
    end

    // tx_valid held high with data changing every cycle.
    hs0 = hs_count;
    f0 = frames_done;
    @(posedge clk);
    #1;
    address = 8'($urandom);
    command = 8'($urandom);
    tx_valid = 1'b1;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk);
          #1;
          if (hs_count >= hs0 + 3) break;
          address = 8'($urandom);
          command = 8'($urandom);
        end
        tx_valid = 1'b0;
      end
      begin
        for (int g = 0; g < 2; g++) begin
          n = 0;
          idle = 0;
          while (!done && n < 3000) begin
            @(negedge clk);
            n++;
          end
          @(negedge clk);
          while (!busy && idle < 10) begin
            idle++;
            @(negedge clk);
          end
          check("b2b_gap", 64'(idle), 64'd1);
        end
      end
    join
    wait_frames(f0 + 3);
    check("accepts_per_frame", 64'(hs_count - hs0), 64'd3);

    // Reset in the first cycle of bit 10's mark.
    a = 8'($urandom);
    c = 8'($urandom);
    d = {~c, c, ~a, a};
    tcyc = 24 * U;
    for (int i = 0; i < 10; i++) tcyc += (d[i] ? 4 : 2) * U;
    f0 = frames_done;
    send(a, c);
    repeat (tcyc) @(posedge clk);
    #3;
    check("pre_reset_mark", 64'({ir_envelope, ir_tx}), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'({tx_ready, busy, ir_tx, ir_envelope}), 64'(4'b1000));
    @(posedge clk);
    #3;
    rst = 1'b0;
    send(8'($urandom), 8'($urandom));
    wait_frames(f0 + 1);
    check("frames_after_reset", 64'(frames_done), 64'(f0 + 1));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("unmodulated_instance", 64'(nm_viol), 64'd0);
    check("idle_line_quiet", 64'(idle_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
